// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the UART echo path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, CHECK, GAP} state_t;
  localparam int OSR_DEF = 16;
  localparam int FRAME_BITS = 10;
  localparam int CNT_W = 16;
  function automatic int calc_div(input int clk_hz, input int baud, input int osr);
    return (clk_hz / (baud * osr) < 1) ? 1 : clk_hz / (baud * osr);
  endfunction
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer, start-bit validation and framing check
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int OSR = OSR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  logic rx_m, rx_s, rx_p, active, mid;
  logic [7:0] tcnt, shreg;
  logic [3:0] bitn;
  assign mid = tick && tcnt == 8'(OSR/2 - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
      active <= 1'b0;
      tcnt <= '0;
      bitn <= '0;
      shreg <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
      valid <= 1'b0;
      if (!active) begin
        active <= rx_p && !rx_s;
        tcnt <= '0;
        bitn <= '0;
      end else if (tick) begin
        tcnt <= tcnt == 8'(OSR - 1) ? '0 : tcnt + 8'd1;
        if (mid) begin
          bitn <= bitn + 4'd1;
          // a start bit that is high again at mid-bit was only a glitch
          if (bitn == 4'd0) active <= !rx_s;
          else if (bitn == 4'd9) begin
            active <= 1'b0;
            data <= shreg;
            frame_err <= !rx_s;
            valid <= 1'b1;
          end else shreg <= {rx_s, shreg[7:1]};
        end
      end
    end
  end
endmodule

// File: rtl/uart_echo_checker.sv
// uart_echo_checker: sends a stepping byte pattern as 8N1, checks the echoed byte
// and keeps saturating pass/error statistics plus sticky failure flags.
module uart_echo_checker
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int OSR = OSR_DEF,
  parameter int TIMEOUT_BITS = 40,
  parameter int GAP_BITS = 2,
  parameter int PATTERN_STEP = 1
) (
  input  logic             clk,
  input  logic             key_reset,
  input  logic             start,
  input  logic             run_continuous,
  input  logic             rx,
  output logic             tx,
  output logic             busy,
  output logic [7:0]       last_sent,
  output logic [7:0]       last_rcvd,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             mismatch,
  output logic             timeout_flag
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OSR);
  state_t state, state_nxt;
  logic [15:0] div_cnt, bit_cnt;
  logic [7:0] osr_cnt, pattern, pat_nxt, rx_data;
  logic rst, tick, bit_end, rx_valid, rx_ferr, tx_d;
  assign rst = ~key_reset;
  assign tick = div_cnt == 16'(DIV - 1);
  assign bit_end = tick && osr_cnt == 8'(OSR - 1);
  assign busy = state != IDLE;
  assign pat_nxt = pattern + 8'(PATTERN_STEP);
  assign tx_d = (state != SEND || bit_cnt >= 16'(FRAME_BITS - 1)) ? 1'b1 :
                bit_cnt == '0 ? 1'b0 : last_sent[3'(bit_cnt - 16'd1)];
  uart_rx_byte #(.OSR(OSR)) u_rx (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx),
    .data(rx_data), .valid(rx_valid), .frame_err(rx_ferr)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = (start || run_continuous) ? SEND : IDLE;
      SEND: state_nxt = (bit_end && bit_cnt == 16'(FRAME_BITS - 1)) ? WAIT_ECHO : SEND;
      WAIT_ECHO: state_nxt = rx_valid ? CHECK :
                             (bit_end && bit_cnt == 16'(TIMEOUT_BITS - 1)) ? GAP : WAIT_ECHO;
      CHECK: state_nxt = GAP;
      GAP: state_nxt = (bit_end && bit_cnt == 16'(GAP_BITS - 1)) ? (run_continuous ? SEND : IDLE) : GAP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      osr_cnt <= '0;
      bit_cnt <= '0;
      tx <= 1'b1;
      pattern <= '0;
      last_sent <= '0;
      last_rcvd <= '0;
      pass_count <= '0;
      err_count <= '0;
      mismatch <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 16'd1;
      // bit timing restarts on every state change so each state counts whole bit periods
      osr_cnt <= (state_nxt != state || bit_end) ? '0 : tick ? osr_cnt + 8'd1 : osr_cnt;
      bit_cnt <= state_nxt != state ? '0 : bit_end ? bit_cnt + 16'd1 : bit_cnt;
      tx <= tx_d;
      if (state == GAP && state_nxt != GAP) pattern <= pat_nxt;
      if (state != SEND && state_nxt == SEND) last_sent <= state == GAP ? pat_nxt : pattern;
      if (state == CHECK) begin
        last_rcvd <= rx_data;
        if (rx_data == last_sent && !rx_ferr) pass_count <= sat_inc(pass_count);
        else begin
          err_count <= sat_inc(err_count);
          mismatch <= 1'b1;
        end
      end
      if (state == WAIT_ECHO && state_nxt == GAP) begin
        err_count <= sat_inc(err_count);
        timeout_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_echo_checker.sv
// tb_uart_echo_checker: directed vector table plus hand sequences against a behavioural echo server
module tb_uart_echo_checker;
  localparam int OSR = 4;
  localparam int BP = OSR;
  localparam int TO = 40;
  localparam int GAPB = 2;
  logic clk = 1'b0;
  logic key_reset = 1'b0;
  logic start = 1'b0;
  logic run_continuous = 1'b0;
  logic rx;
  logic tx, busy, mismatch, timeout_flag;
  logic [7:0] last_sent, last_rcvd;
  logic [15:0] pass_count, err_count;
  int total = 0;
  int bad = 0;
  int frames = 0;
  int mode = 0;
  typedef struct {
    int mode;
    int n;
    int pass;
    int err;
    logic [7:0] sent;
    logic [7:0] rcvd;
    logic mm;
    logic to;
  } vec_t;
  vec_t vecs[7];

  uart_echo_checker #(
    .CLK_HZ(400), .BAUD(100), .OSR(OSR), .TIMEOUT_BITS(TO), .GAP_BITS(GAPB), .PATTERN_STEP(1)
  ) dut (
    .clk(clk), .key_reset(key_reset), .start(start), .run_continuous(run_continuous),
    .rx(rx), .tx(tx), .busy(busy), .last_sent(last_sent), .last_rcvd(last_rcvd),
    .pass_count(pass_count), .err_count(err_count), .mismatch(mismatch), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] v, input logic stop);
    rx = 1'b0;
    repeat (BP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (BP) @(negedge clk);
    end
    rx = stop;
    repeat (BP) @(negedge clk);
    rx = 1'b1;
  endtask

  // echo server: 0 echo, 1 xor 0x01, 2 zero byte with low stop bit, 3 silent, 4 glitch then echo
  initial begin
    logic [7:0] b;
    rx = 1'b1;
    forever begin
      @(negedge tx);
      frames++;
      @(negedge clk);
      repeat (BP/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BP) @(negedge clk);
        b[i] = tx;
      end
      repeat (BP + BP/2) @(negedge clk);
      case (mode)
        0: send(b, 1'b1);
        1: send(b ^ 8'h01, 1'b1);
        2: send(8'h00, 1'b0);
        4: begin
          rx = 1'b0;
          @(negedge clk);
          rx = 1'b1;
          repeat (3*BP) @(negedge clk);
          send(b, 1'b1);
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    key_reset = 1'b0;
    repeat (3) @(negedge clk);
    key_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int k = 0;
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_frames(input string name, input int target, input int lim);
    int k = 0;
    while (frames < target && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_frames"}, {31'd0, frames >= target}, 32'd1);
  endtask

  initial begin
    int base, cnt;
    string nm;
    vecs[0] = '{0, 1, 1, 0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{3, 1, 0, 1, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{1, 3, 0, 3, 8'h02, 8'h03, 1'b1, 1'b0};
    vecs[3] = '{2, 1, 0, 1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{4, 1, 1, 0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{0, 5, 5, 0, 8'h04, 8'h04, 1'b0, 1'b0};
    vecs[6] = '{0, 257, 257, 0, 8'h00, 8'h00, 1'b0, 1'b0};

    do_reset();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pass", {16'd0, pass_count}, 32'd0);
    chk("rst_err", {16'd0, err_count}, 32'd0);
    chk("rst_sent", {24'd0, last_sent}, 32'd0);
    chk("rst_flags", {30'd0, mismatch, timeout_flag}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      nm = $sformatf("vec%0d", v);
      do_reset();
      mode = vecs[v].mode;
      base = frames;
      if (vecs[v].n == 1) begin
        pulse_start();
        chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      end else begin
        run_continuous = 1'b1;
        wait_frames(nm, base + vecs[v].n, vecs[v].n * 200 + 200);
        run_continuous = 1'b0;
      end
      wait_idle(nm, 1000);
      chk({nm, "_pass"}, {16'd0, pass_count}, vecs[v].pass);
      chk({nm, "_err"}, {16'd0, err_count}, vecs[v].err);
      chk({nm, "_sent"}, {24'd0, last_sent}, {24'd0, vecs[v].sent});
      chk({nm, "_rcvd"}, {24'd0, last_rcvd}, {24'd0, vecs[v].rcvd});
      chk({nm, "_mismatch"}, {31'd0, mismatch}, {31'd0, vecs[v].mm});
      chk({nm, "_timeout"}, {31'd0, timeout_flag}, {31'd0, vecs[v].to});
    end

    // silent echo: busy spans the frame, the full timeout and the gap
    do_reset();
    mode = 3;
    pulse_start();
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_busy_width", cnt, (10 + TO + GAPB) * BP);
    chk("timeout_err", {16'd0, err_count}, 32'd1);

    // reset during d3 of the second frame (pattern 0x01, d3 low)
    do_reset();
    mode = 0;
    pulse_start();
    wait_idle("pre", 1000);
    chk("pre_pass", {16'd0, pass_count}, 32'd1);
    base = frames;
    pulse_start();
    wait_frames("midrst", base + 1, 200);
    repeat (4*BP + 1) @(negedge clk);
    key_reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pass", {16'd0, pass_count}, 32'd0);
    chk("midrst_sent", {24'd0, last_sent}, 32'd0);
    key_reset = 1'b1;
    repeat (60*BP) @(negedge clk);
    chk("midrst_quiet_pass", {16'd0, pass_count}, 32'd0);
    pulse_start();
    wait_idle("post", 1000);
    chk("post_pass", {16'd0, pass_count}, 32'd1);
    chk("post_err", {16'd0, err_count}, 32'd0);
    chk("post_sent", {24'd0, last_sent}, 32'd0);
    chk("post_rcvd", {24'd0, last_rcvd}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_echo_checker.md
Name: uart_echo_checker

Overview:
Host-side initiator for the UART echo path; the opposite end of the FPGA echo server. It serializes a deterministic byte pattern onto tx as 8N1, deserializes the returning byte on rx, compares it to the byte sent, and accumulates pass/error statistics. It is instantiated in bench tops and in a self-test top wired to a second UART header, with the summary outputs driving the status LEDs.

Parameters:
CLK_HZ, 50000000, input clock frequency.
BAUD, 115200, line rate.
OSR, 16, oversample ticks per bit; the divider is CLK_HZ/(BAUD*OSR), truncated (27 at defaults).
TIMEOUT_BITS, 40, bit periods to wait for an echo start bit after our stop bit completes.
GAP_BITS, 2, idle bit periods between transactions in continuous mode.
PATTERN_STEP, 1, increment applied to the pattern byte per transaction, modulo 256.

Ports:
clk  in  1  system clock, 50 MHz.
key_reset  in  1  synchronous, active-low reset.
start  in  1  single-cycle pulse; launches one transaction when idle.
run_continuous  in  1  while high, transactions repeat back to back.
rx  in  1  asynchronous serial input from the echo server.
tx  out  1  serial output to the echo server; idles high.
busy  out  1  high from start accept until return to IDLE.
last_sent  out  8  pattern byte of the most recent transaction.
last_rcvd  out  8  most recently received echo byte.
pass_count  out  16  matched echoes, saturating.
err_count  out  16  mismatches, framing errors and timeouts, saturating.
mismatch  out  1  sticky; set on any data mismatch or framing error.
timeout_flag  out  1  sticky; set on any echo timeout.

Behaviour:
- Reset, sampled on the clk edge while key_reset=0: tx=1, busy=0, all counters, bytes and flags at 0, pattern register at 0x00, FSM in IDLE, tick divider cleared. Reset mid-frame drives tx=1 on the next edge; the partial frame is abandoned.
- Tick generator: free-running divider emits a 1-cycle tick every DIV clocks. A bit period is OSR ticks.
- FSM states:
  - IDLE -> SEND when start=1 or run_continuous=1. start while busy is ignored.
  - SEND: frame is start(0), d0..d7 LSB first, stop(1), each OSR ticks. last_sent is loaded at SEND entry. After the stop bit -> WAIT_ECHO.
  - WAIT_ECHO: timeout counter counts bit periods. A received byte -> CHECK. Reaching TIMEOUT_BITS -> err_count+1, timeout_flag=1, then -> GAP.
  - CHECK (1 cycle): the received byte is written to last_rcvd. Equal and no framing error -> pass_count+1; otherwise err_count+1 and mismatch=1. Then -> GAP.
  - GAP: wait GAP_BITS bit periods, pattern += PATTERN_STEP, then -> SEND if run_continuous=1, else IDLE.
- RX deserializer:
  - rx passes through a 2-flop synchronizer.
  - A falling edge starts a frame. The start bit is re-checked at tick OSR/2; if high, the frame is a glitch and is dropped with no count.
  - Data bits are sampled at the mid-bit of each following period.
  - Stop bit sampled 0 is a framing error; the byte is still delivered to CHECK and counted as an error.
- RX outside WAIT_ECHO: runs continuously, but bytes completing in any other state are discarded. A start bit already in progress at timeout is still discarded.
- Counters saturate at 0xFFFF; no wrap.
- The pattern wraps 0xFF->0x00 under modulo 256.
- busy=1 in every state except IDLE. Sticky flags clear only on reset.
- Latency:
  - stop bit ends (1 + 8 + 1) * OSR * DIV clocks after SEND entry.
  - counters update one clk after the echo stop-bit mid-sample.

Decomposition:
- Shared package uart_pkg:
  - state enum
  - OSR default
  - function computing DIV from CLK_HZ/BAUD
  - frame length constant (10 bits)
  - counter width (16)
- Sub-module uart_rx_byte holds the synchronizer, start validation, sampling and framing check. It outputs a byte, a valid pulse and a frame_err flag; the echo server side can reuse it.
- The TX serializer, tick divider and FSM stay in the top.

Test Plan:
1. Echo model loops tx->rx with 1-bit delay; pulse start once -> last_sent=0x00, last_rcvd=0x00, pass_count=1, err_count=0, busy falls after the GAP period.
2. rx tied high; pulse start -> after 40 bit periods timeout_flag=1, err_count=1, pass_count=0, FSM back in IDLE.
3. Echo model XORs the byte with 0x01; run_continuous for 3 transactions -> err_count=3, mismatch=1, last_rcvd=0x03 (sent 0x02).
4. Echo model returns 0x00 with stop bit=0 -> framing error: err_count=1, mismatch=1, pass_count=0.
5. run_continuous with a correct echo for 257 transactions -> pattern wraps; last_sent=0x00 on the 257th, pass_count=257.
6. Assert key_reset low during d3 of SEND -> tx=1 next edge, all outputs at 0, a subsequent start yields normal pass.
